// File: rtl/wb_slave_mux.sv
// ---------------------------------------------------------------------------
// wb_slave_mux
//
// Wishbone classic slave decoder / multiplexer. It sits between the core's
// 16-bit bus (one master) and N_SLAVES peripheral slaves. Address decode is
// driven by a table of inclusive ranges. All slave-side signals are
// registered. Only one transaction can be in flight at a time.
//
// For every accepted access the block returns exactly one single-cycle pulse
// on m_ack or on m_err. The one exception is an access abandoned by reset or
// by the master dropping m_cyc; that access gets no pulse.
//
// Optional feature macro: WB_SLAVE_MUX_ERRLOG_EN
//   When defined, an error log adds the ports o_err_adr, o_err_src and
//   o_err_cnt. It records the address and cause of the most recent m_err
//   pulse and counts errors, saturating at 255.
//
// Ports
//   d_clk      clock (rising edge)
//   i_rst      synchronous reset, active low
//   m_cyc      master cycle
//   m_stb      master strobe
//   m_we       master write enable
//   m_adr      master word address       [ADDR_W]
//   m_dat_w    master write data         [DATA_W]
//   m_sel      master byte select        [SEL_W]
//   m_dat_r    read data to master, registered, holds between accesses
//   m_ack      acknowledge, 1-cycle registered pulse
//   m_err      bus error (unmapped / timeout / slave error), 1-cycle pulse
//   s_cyc      shared cycle to all slaves
//   s_stb      one-hot strobe            [N_SLAVES]
//   s_we       registered write enable
//   s_adr      registered address offset inside the selected slave
//   s_dat_w    registered write data
//   s_sel      registered byte select
//   s_dat_r    packed slave read data    [N_SLAVES*DATA_W]
//   s_ack      slave acknowledges        [N_SLAVES]
//   s_err      slave errors              [N_SLAVES]
//   o_err_adr  (ERRLOG) address of the last errored access
//   o_err_src  (ERRLOG) cause: 0 unmapped, 1 timeout, 2 slave error
//   o_err_cnt  (ERRLOG) saturating error count
// ---------------------------------------------------------------------------
module wb_slave_mux #(
  parameter int                         N_SLAVES   = 6,
  parameter int                         ADDR_W     = 24,
  parameter int                         DATA_W     = 16,
  parameter int                         SEL_W      = 2,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_END  = '0,
  parameter int                         TIMEOUT    = 255
) (
  input  logic                         d_clk,
  input  logic                         i_rst,
  input  logic                         m_cyc,
  input  logic                         m_stb,
  input  logic                         m_we,
  input  logic [ADDR_W-1:0]            m_adr,
  input  logic [DATA_W-1:0]            m_dat_w,
  input  logic [SEL_W-1:0]             m_sel,
  output logic [DATA_W-1:0]            m_dat_r,
  output logic                         m_ack,
  output logic                         m_err,
  output logic                         s_cyc,
  output logic [N_SLAVES-1:0]          s_stb,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_adr,
  output logic [DATA_W-1:0]            s_dat_w,
  output logic [SEL_W-1:0]             s_sel,
  input  logic [N_SLAVES*DATA_W-1:0]   s_dat_r,
  input  logic [N_SLAVES-1:0]          s_ack,
  input  logic [N_SLAVES-1:0]          s_err
`ifdef WB_SLAVE_MUX_ERRLOG_EN
  ,
  output logic [ADDR_W-1:0]            o_err_adr,
  output logic [1:0]                   o_err_src,
  output logic [7:0]                   o_err_cnt
`endif
);

  // Index width is kept at least 1 bit so that a single-slave build still works.
  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  // The counter must be able to hold TIMEOUT itself. It is 1 bit wide when the
  // watchdog is disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] SRC_UNMAPPED = 2'd0;
  localparam logic [1:0] SRC_TIMEOUT  = 2'd1;
  localparam logic [1:0] SRC_SLVERR   = 2'd2;

  localparam logic [N_SLAVES-1:0] STB_ONE = N_SLAVES'(1);

  // State and captured request
  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [IDX_W-1:0]    idx_r;
  logic [ADDR_W-1:0]   adr_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic                timeout_s;

  // Decode results for the current m_adr
  logic                hit_s;
  logic [IDX_W-1:0]    idx_s;
  logic [ADDR_W-1:0]   off_s;

  // Response of the selected slave
  logic                sel_ack_s;
  logic                sel_err_s;
  logic [DATA_W-1:0]   sel_dat_s;

  // Control decisions of the current cycle
  logic                accept_s;
  logic                go_ack_s;
  logic                go_err_s;
  logic                cap_dat_s;
  logic [1:0]          err_src_s;
  logic [IDX_W-1:0]    idx_nxt_s;
  logic [N_SLAVES-1:0] stb_nxt_s;
  logic [ADDR_W-1:0]   err_adr_s;

  // Range decode. The loop walks from the highest slave down to the lowest so
  // that the lowest matching index is the last one written and wins overlaps.
  always_comb begin
    hit_s = 1'b0;
    idx_s = '0;
    off_s = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if ((m_adr >= SLAVE_BASE[k*ADDR_W +: ADDR_W]) &&
          (m_adr <= SLAVE_END[k*ADDR_W +: ADDR_W])) begin
        hit_s = 1'b1;
        idx_s = IDX_W'(k);
        off_s = m_adr - SLAVE_BASE[k*ADDR_W +: ADDR_W];
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Only the registered (selected) slave is listened to. Acks and errors from
  // the other slaves never reach the FSM.
  assign sel_ack_s = s_ack[idx_r];
  assign sel_err_s = s_err[idx_r];
  assign sel_dat_s = s_dat_r[idx_r*DATA_W +: DATA_W];

  // The watchdog fires on the ACTIVE cycle that brings the count up to
  // TIMEOUT, so s_stb stays high for exactly TIMEOUT cycles.
  assign cnt_inc_s = cnt_r + CNT_W'(1);
  assign timeout_s = (TIMEOUT != 0) && (cnt_inc_s == CNT_W'(TIMEOUT));

  // Next-state logic and response decisions
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    go_ack_s    = 1'b0;
    go_err_s    = 1'b0;
    cap_dat_s   = 1'b0;
    err_src_s   = SRC_UNMAPPED;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = '0;
        if (m_cyc && m_stb) begin
          accept_s = 1'b1;
          if (hit_s) begin
            state_nxt_s = ST_ACTIVE;
          end else begin
            state_nxt_s = ST_RESP;
            go_err_s    = 1'b1;
            err_src_s   = SRC_UNMAPPED;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // A master that gives up wins over any response in the same cycle.
        if (!m_cyc) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end else if (sel_err_s) begin
          state_nxt_s = ST_RESP;
          go_err_s    = 1'b1;
          err_src_s   = SRC_SLVERR;
        end else if (sel_ack_s) begin
          state_nxt_s = ST_RESP;
          go_ack_s    = 1'b1;
          cap_dat_s   = 1'b1;
        end else if (timeout_s) begin
          state_nxt_s = ST_RESP;
          go_err_s    = 1'b1;
          err_src_s   = SRC_TIMEOUT;
          cnt_nxt_s   = cnt_inc_s;
        end else begin
          state_nxt_s = ST_ACTIVE;
          // With the watchdog disabled the counter stays at zero and never
          // wraps.
          if (TIMEOUT != 0) begin
            cnt_nxt_s = cnt_inc_s;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // The strobe is computed one cycle ahead so that it comes straight from a
  // flop while ACTIVE. It drops on the same edge that leaves ACTIVE.
  always_comb begin
    if (accept_s) begin
      idx_nxt_s = idx_s;
    end else begin
      idx_nxt_s = idx_r;
    end
    if (state_nxt_s == ST_ACTIVE) begin
      stb_nxt_s = STB_ONE << idx_nxt_s;
    end else begin
      stb_nxt_s = '0;
    end
  end

  // The logged address is the one being captured on an unmapped access, and
  // the held copy otherwise.
  assign err_adr_s = accept_s ? m_adr : adr_r;

  // FSM state and watchdog counter
  always_ff @(posedge d_clk) begin
    if (!i_rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Request capture and slave-side bus registers
  always_ff @(posedge d_clk) begin
    if (!i_rst) begin
      idx_r   <= '0;
      adr_r   <= '0;
      s_we    <= 1'b0;
      s_adr   <= '0;
      s_dat_w <= '0;
      s_sel   <= '0;
      s_cyc   <= 1'b0;
      s_stb   <= '0;
    end else begin
      if (accept_s) begin
        idx_r   <= idx_s;
        adr_r   <= m_adr;
        s_we    <= m_we;
        s_adr   <= off_s;
        s_dat_w <= m_dat_w;
        s_sel   <= m_sel;
      end else begin
        idx_r   <= idx_r;
        adr_r   <= adr_r;
        s_we    <= s_we;
        s_adr   <= s_adr;
        s_dat_w <= s_dat_w;
        s_sel   <= s_sel;
      end
      s_cyc <= (state_nxt_s == ST_ACTIVE);
      s_stb <= stb_nxt_s;
    end
  end

  // Master-side response pulses and read data. Read data is captured on an
  // accepted ack only, for writes as well as reads.
  always_ff @(posedge d_clk) begin
    if (!i_rst) begin
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      m_dat_r <= '0;
    end else begin
      m_ack <= go_ack_s;
      m_err <= go_err_s;
      if (cap_dat_s) begin
        m_dat_r <= sel_dat_s;
      end else begin
        m_dat_r <= m_dat_r;
      end
    end
  end

`ifdef WB_SLAVE_MUX_ERRLOG_EN
  // Error log. It is updated on the same edge that raises m_err, so the log
  // is already valid during the pulse.
  always_ff @(posedge d_clk) begin
    if (!i_rst) begin
      o_err_adr <= '0;
      o_err_src <= 2'd0;
      o_err_cnt <= 8'd0;
    end else if (go_err_s) begin
      o_err_adr <= err_adr_s;
      o_err_src <= err_src_s;
      if (o_err_cnt != 8'hFF) begin
        o_err_cnt <= o_err_cnt + 8'd1;
      end else begin
        o_err_cnt <= o_err_cnt;
      end
    end else begin
      o_err_adr <= o_err_adr;
      o_err_src <= o_err_src;
      o_err_cnt <= o_err_cnt;
    end
  end
`else
  // Without the log, the cause and address are computed but have no consumer.
  logic unused_s;
  assign unused_s = ^{err_adr_s, err_src_s};
`endif

endmodule

// File: doc/wb_slave_mux.md
Name: wb_slave_mux

Overview:
- Parametrised Wishbone classic slave decoder/multiplexer between the core's decompressed 16-bit bus and N peripheral slaves.
- Replaces hand-written address compare chains and combinational ack muxing with a registered, table-driven decoder.
- Adds features the hand-written decode lacks: per-transaction timeout watchdog, explicit bus error on unmapped addresses, and slave error forwarding.
- One transaction in flight; m_ack/m_err are always registered single-cycle pulses.

Parameters:
- N_SLAVES, 6, number of slave ports (1..16).
- ADDR_W, 24, Wishbone address width (word addresses).
- DATA_W, 16, data width.
- SEL_W, 2, byte-select width.
- SLAVE_BASE, {N_SLAVES*ADDR_W}'0, packed base addresses; slave k occupies bits [k*ADDR_W +: ADDR_W].
- SLAVE_END, {N_SLAVES*ADDR_W}'0, packed inclusive end addresses, same packing.
- TIMEOUT, 255, cycles to wait for a slave response; 0 disables the watchdog.

Ports:
- d_clk  in  1  clock
- i_rst  in  1  reset
- m_cyc  in  1  master cycle
- m_stb  in  1  master strobe
- m_we  in  1  write enable
- m_adr  in  ADDR_W  address
- m_dat_w  in  DATA_W  write data
- m_sel  in  SEL_W  byte select
- m_dat_r  out  DATA_W  read data, registered
- m_ack  out  1  transaction acknowledge, 1-cycle pulse
- m_err  out  1  bus error (unmapped/timeout/slave error), 1-cycle pulse
- s_cyc  out  1  shared cycle to slaves
- s_stb  out  N_SLAVES  one-hot strobe
- s_we  out  1  registered write enable
- s_adr  out  ADDR_W  registered address offset (m_adr - SLAVE_BASE[idx])
- s_dat_w  out  DATA_W  registered write data
- s_sel  out  SEL_W  registered byte select
- s_dat_r  in  N_SLAVES*DATA_W  packed slave read data
- s_ack  in  N_SLAVES  slave acks
- s_err  in  N_SLAVES  slave errors

Behaviour:
- Reset is synchronous, active-low: i_rst sampled low at a d_clk rising edge resets the block. Clock is d_clk.
- Reset effect: state = IDLE; m_ack, m_err, s_cyc, s_stb, s_we = 0; m_dat_r, s_adr, s_dat_w, s_sel = 0; timeout counter = 0.
- Reset mid-transaction: the in-flight access is abandoned with no ack and no err.
- Address decode: slave k matches when SLAVE_BASE[k] <= m_adr <= SLAVE_END[k]. If ranges overlap, the lowest k wins.
- IDLE:
  - On m_cyc & m_stb, register the winning index, the offset, m_we, m_dat_w and m_sel.
  - If a slave matches, go to ACTIVE; if none matches, go to RESP with the error flag set.
- ACTIVE:
  - s_cyc = 1 and s_stb[idx] = 1, driven from registers; all other s_stb bits are 0.
  - s_ack[idx] sampled high: capture s_dat_r[idx] into m_dat_r (also on writes), go to RESP with ack.
  - s_err[idx] sampled high: go to RESP with error. If s_ack and s_err are both high, s_err takes priority.
  - Counter increments each ACTIVE cycle. When it reaches TIMEOUT with no response, drop s_stb and go to RESP with error.
  - m_cyc sampled low: abort to IDLE, no ack/err pulse.
  - Acks or errs from non-selected slaves are ignored.
- RESP:
  - Exactly one of m_ack / m_err is high for this one cycle.
  - s_stb = 0, counter cleared, next state IDLE.
  - The master drops m_stb on the edge ending RESP, so the following IDLE cycle does not re-issue the access.
- Latency: request sampled at cycle 0, ACTIVE at cycle 1, slave ack combinational in cycle 1 gives m_ack in cycle 2. Minimum 2 cycles; unmapped error also returns in cycle 1 (IDLE to RESP).
- m_dat_r holds its value between transactions. It is updated only on an accepted s_ack.
- Counter width is $clog2(TIMEOUT+1) and the counter never wraps. With TIMEOUT = 0 the block waits indefinitely.

Optional Feature:
- Macro: WB_SLAVE_MUX_ERRLOG_EN.
- Defined: adds output ports o_err_adr (ADDR_W), o_err_src (2 bits: 0 unmapped, 1 timeout, 2 slave err) and o_err_cnt (8 bits).
  - Every m_err pulse latches m_adr's registered copy into o_err_adr and the cause into o_err_src.
  - o_err_cnt increments and saturates at 255.
  - All three reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Read, slave 2 [0x002008..0x00200a] with combinational ack and s_dat_r = 0xBEEF; m_adr = 0x002009 -> s_stb = 6'b000100, s_adr = 1, m_ack pulses exactly in cycle 2, m_dat_r = 0xBEEF.
- Write to m_adr = 0xFFE010 with no mapped slave -> no s_stb, m_err pulses in cycle 1, m_ack stays 0; with ERRLOG_EN, o_err_adr = 0xFFE010, o_err_src = 0, o_err_cnt = 1.
- Slave never acks, TIMEOUT = 8 -> s_stb high for 8 cycles then low; one m_err pulse; the next request to another slave completes normally.
- Slave asserts s_ack and s_err in the same cycle -> m_err = 1, m_ack = 0, m_dat_r unchanged.
- i_rst low during ACTIVE -> next cycle all outputs at reset values, no ack/err pulse; m_cyc dropped in ACTIVE -> IDLE, no pulse.
- Overlapping ranges (slaves 0 and 3 both cover 0x100000) -> only s_stb[0] asserted; an ack from slave 3 is ignored.
